// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: base opcodes, control-field bit positions and ALU operation codes.
package rv32i_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // id_ex_control = {jump, branch_op, lui, auipc, alu_src_imm, alu_op[1:0]}
   localparam int unsigned EX_CTRL_W    = 7;
   localparam int unsigned EX_JUMP      = 6;
   localparam int unsigned EX_BRANCH    = 5;
   localparam int unsigned EX_LUI       = 4;
   localparam int unsigned EX_AUIPC     = 3;
   localparam int unsigned EX_ALU_SRC   = 2;
   localparam int unsigned EX_ALUOP_LSB = 0;
   localparam int unsigned ALU_OP_W     = 2;

   localparam int unsigned MEM_CTRL_W = 2;
   localparam int unsigned MEM_READ   = 1;
   localparam int unsigned MEM_WRITE  = 0;

   localparam int unsigned WB_CTRL_W     = 2;
   localparam int unsigned WB_REG_WRITE  = 1;
   localparam int unsigned WB_MEM_TO_REG = 0;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD    = 2'b00,
      ALU_BRANCH = 2'b01,
      ALU_REG    = 2'b10,
      ALU_IMM    = 2'b11
   } alu_op_e;

endpackage

// File: rtl/id_decode_stage_regfile_2r1w.sv
// Architectural register file: two combinational read ports, one write port, x0 hardwired to zero.
module regfile_2r1w
   import rv32i_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   raddr1_i,
   input  logic [AW-1:0]   raddr2_i,
   output logic [XLEN-1:0] rdata1_o,
   output logic [XLEN-1:0] rdata2_o,
   input  logic            we_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [XLEN-1:0] wdata_i
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic            wr_en;

   assign wr_en = we_i && (waddr_i != '0);

   // Reset takes priority so a same-cycle writeback is discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata1_o = '0;
      rdata2_o = '0;
      if (raddr1_i != '0) rdata1_o = (wr_en && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
      if (raddr2_i != '0) rdata2_o = (wr_en && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];
   end

endmodule

// File: rtl/id_decode_stage.sv
// RV32I instruction-decode stage: control decode, immediate generation, register read and load-use detection.
module id_decode_stage
   import rv32i_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           if_instr,
   input  logic [31:0]           if_pc,
   input  logic                  if_valid,
   input  logic                  branch,
   input  logic [4:0]            ex_rd,
   input  logic                  ex_mem_read,
   input  logic [4:0]            wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   input  logic                  wb_reg_write,
   output logic [4:0]            id_rd,
   output logic [4:0]            id_Rs1,
   output logic [4:0]            id_Rs2,
   output logic [31:0]           id_pc,
   output logic [XLEN-1:0]       id_rs1,
   output logic [XLEN-1:0]       id_rs2,
   output logic [31:0]           id_immediate,
   output logic [2:0]            id_funct_3,
   output logic [6:0]            id_funct_7,
   output logic [6:0]            id_opcode,
   output logic [EX_CTRL_W-1:0]  id_ex_control,
   output logic [MEM_CTRL_W-1:0] id_mem_control,
   output logic [WB_CTRL_W-1:0]  id_wb_control,
   output logic                  load_use_stall,
   output logic                  illegal_instr
);

   logic [6:0]            opcode;
   logic                  legal, rs1_used, rs2_used, bubble;
   logic [31:0]           imm;
   logic [EX_CTRL_W-1:0]  ex_ctrl;
   logic [MEM_CTRL_W-1:0] mem_ctrl;
   logic [WB_CTRL_W-1:0]  wb_ctrl;
   logic                  illegal_q, illegal_d;

   assign opcode       = if_instr[6:0];
   assign id_opcode    = opcode;
   assign id_rd        = if_instr[11:7];
   assign id_Rs1       = if_instr[19:15];
   assign id_Rs2       = if_instr[24:20];
   assign id_funct_3   = if_instr[14:12];
   assign id_funct_7   = if_instr[31:25];
   assign id_pc        = if_pc;
   assign id_immediate = imm;

   regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS), .AW(5)) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .raddr1_i (if_instr[19:15]),
      .raddr2_i (if_instr[24:20]),
      .rdata1_o (id_rs1),
      .rdata2_o (id_rs2),
      .we_i     (wb_reg_write),
      .waddr_i  (wb_rd),
      .wdata_i  (wb_data)
   );

   always_comb begin
      legal    = 1'b1;
      rs1_used = 1'b1;
      rs2_used = 1'b0;
      imm      = '0;
      ex_ctrl  = '0;
      mem_ctrl = '0;
      wb_ctrl  = '0;
      unique case (opcode)
         OP_LOAD: begin
            imm = {{20{if_instr[31]}}, if_instr[31:20]};
            ex_ctrl[EX_ALU_SRC]     = 1'b1;
            mem_ctrl[MEM_READ]      = 1'b1;
            wb_ctrl[WB_REG_WRITE]   = 1'b1;
            wb_ctrl[WB_MEM_TO_REG]  = 1'b1;
         end
         OP_STORE: begin
            imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            rs2_used = 1'b1;
            ex_ctrl[EX_ALU_SRC]  = 1'b1;
            mem_ctrl[MEM_WRITE]  = 1'b1;
         end
         OP_BRANCH: begin
            imm = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
            rs2_used = 1'b1;
            ex_ctrl[EX_BRANCH] = 1'b1;
            ex_ctrl[EX_ALUOP_LSB +: ALU_OP_W] = ALU_BRANCH;
         end
         OP_JAL: begin
            imm = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
            rs1_used = 1'b0;
            ex_ctrl[EX_JUMP]      = 1'b1;
            wb_ctrl[WB_REG_WRITE] = 1'b1;
         end
         OP_JALR: begin
            imm = {{20{if_instr[31]}}, if_instr[31:20]};
            ex_ctrl[EX_JUMP]      = 1'b1;
            ex_ctrl[EX_ALU_SRC]   = 1'b1;
            wb_ctrl[WB_REG_WRITE] = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            imm = {if_instr[31:12], 12'b0};
            rs1_used = 1'b0;
            ex_ctrl[EX_LUI]       = (opcode == OP_LUI);
            ex_ctrl[EX_AUIPC]     = (opcode == OP_AUIPC);
            ex_ctrl[EX_ALU_SRC]   = 1'b1;
            wb_ctrl[WB_REG_WRITE] = 1'b1;
         end
         OP_IMM: begin
            imm = {{20{if_instr[31]}}, if_instr[31:20]};
            ex_ctrl[EX_ALU_SRC]   = 1'b1;
            ex_ctrl[EX_ALUOP_LSB +: ALU_OP_W] = ALU_IMM;
            wb_ctrl[WB_REG_WRITE] = 1'b1;
         end
         OP_REG: begin
            rs2_used = 1'b1;
            ex_ctrl[EX_ALUOP_LSB +: ALU_OP_W] = ALU_REG;
            wb_ctrl[WB_REG_WRITE] = 1'b1;
         end
         OP_FENCE, OP_SYSTEM: ;
         default: legal = 1'b0;
      endcase
   end

   // A taken branch suppresses the stall so IF is free to redirect.
   assign load_use_stall = if_valid && !branch && !reset && ex_mem_read && (ex_rd != 5'd0) &&
                           ((ex_rd == if_instr[19:15] && rs1_used) ||
                            (ex_rd == if_instr[24:20] && rs2_used));

   assign bubble         = load_use_stall || branch || !if_valid || reset || !legal;
   assign id_ex_control  = bubble ? '0 : ex_ctrl;
   assign id_mem_control = bubble ? '0 : mem_ctrl;
   assign id_wb_control  = bubble ? '0 : wb_ctrl;

   always_comb begin
      illegal_d = illegal_q;
      if (if_valid && !branch && !legal) illegal_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) illegal_q <= 1'b0;
      else       illegal_q <= illegal_d;
   end

   assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed scoreboard bench for id_decode_stage.
module tb_id_decode_stage;

   logic        clk = 1'b0;
   logic        reset, if_valid, branch, ex_mem_read, wb_reg_write;
   logic [31:0] if_instr, if_pc, wb_data;
   logic [4:0]  ex_rd, wb_rd;
   logic [4:0]  id_rd, id_Rs1, id_Rs2;
   logic [31:0] id_pc, id_rs1, id_rs2, id_immediate;
   logic [2:0]  id_funct_3;
   logic [6:0]  id_funct_7, id_opcode, id_ex_control;
   logic [1:0]  id_mem_control, id_wb_control;
   logic        load_use_stall, illegal_instr;

   id_decode_stage #(.XLEN(32), .NREGS(32)) dut (
      .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
      .branch(branch), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_reg_write(wb_reg_write), .id_rd(id_rd), .id_Rs1(id_Rs1),
      .id_Rs2(id_Rs2), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_immediate(id_immediate), .id_funct_3(id_funct_3), .id_funct_7(id_funct_7),
      .id_opcode(id_opcode), .id_ex_control(id_ex_control), .id_mem_control(id_mem_control),
      .id_wb_control(id_wb_control), .load_use_stall(load_use_stall), .illegal_instr(illegal_instr)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] ADD_6_5_0 = 32'h00028333;
   localparam logic [31:0] ADD_6_0_0 = 32'h00000333;
   localparam logic [31:0] ADD_6_5_7 = 32'h00728333;
   localparam logic [31:0] BEQ_M4    = 32'hFE000EE3;
   localparam logic [31:0] LUI_X1    = 32'hABCDE0B7;
   localparam logic [31:0] SW_12     = 32'h0072A623;
   localparam logic [31:0] LW_M1     = 32'hFFF2A483;
   localparam logic [31:0] JAL_2048  = 32'h001000EF;
   localparam logic [31:0] FENCE     = 32'h0000000F;
   localparam logic [31:0] BAD_OP    = 32'h0000007F;

   string       tag_q[$];
   logic [31:0] exp_q[$];
   int unsigned vecs = 0;
   int unsigned errs = 0;

   task automatic expect_v(input string tag, input logic [31:0] e);
      tag_q.push_back(tag);
      exp_q.push_back(e);
   endtask

   task automatic compare(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         errs++;
         $display("FAIL scoreboard_empty observed=%h expected=none", obs);
         return;
      end
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      vecs++;
      assert (obs === e) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; if_valid = 1'b1; if_instr = ADD_6_5_7; if_pc = 32'h100; branch = 1'b0;
      ex_rd = 5'd5; ex_mem_read = 1'b1; wb_rd = 5'd0; wb_data = '0; wb_reg_write = 1'b0;
      next_cycle();
      expect_v("reset_ex_ctrl", 32'h0); expect_v("reset_stall", 32'h0);
      expect_v("reset_wb_ctrl", 32'h0); expect_v("reset_mem_ctrl", 32'h0);
      #2;
      compare(32'(id_ex_control)); compare(32'(load_use_stall));
      compare(32'(id_wb_control)); compare(32'(id_mem_control));
      next_cycle();
      expect_v("reset_illegal", 32'h0);
      #2; compare(32'(illegal_instr));

      // WB write x5 with same-cycle read: bypass
      reset = 1'b0; ex_mem_read = 1'b0; if_instr = ADD_6_5_0;
      wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
      expect_v("bypass_rs1", 32'hDEADBEEF); expect_v("bypass_rs2_x0", 32'h0);
      expect_v("add_ex_ctrl", 32'h02); expect_v("add_wb_ctrl", 32'h2);
      expect_v("add_rd", 32'd6); expect_v("add_rs1_idx", 32'd5); expect_v("pc_pass", 32'h100);
      #2;
      compare(id_rs1); compare(id_rs2); compare(32'(id_ex_control));
      compare(32'(id_wb_control)); compare(32'(id_rd)); compare(32'(id_Rs1)); compare(id_pc);
      next_cycle();
      wb_reg_write = 1'b0;
      expect_v("x5_stored", 32'hDEADBEEF);
      #2; compare(id_rs1);

      // Write to x0 is dropped
      next_cycle();
      if_instr = ADD_6_0_0; wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
      expect_v("x0_bypass_blocked", 32'h0);
      #2; compare(id_rs1);
      next_cycle();
      wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'h00001111;
      expect_v("x0_after_write", 32'h0);
      #2; compare(id_rs1);
      next_cycle();
      wb_reg_write = 1'b0;

      // Load-use on rs1
      if_instr = ADD_6_5_7; ex_mem_read = 1'b1; ex_rd = 5'd5;
      expect_v("lu_stall_rs1", 32'h1); expect_v("lu_ex_ctrl", 32'h0);
      expect_v("lu_mem_ctrl", 32'h0); expect_v("lu_wb_ctrl", 32'h0);
      expect_v("lu_rs1_data", 32'hDEADBEEF); expect_v("lu_rs2_data", 32'h00001111);
      #2;
      compare(32'(load_use_stall)); compare(32'(id_ex_control)); compare(32'(id_mem_control));
      compare(32'(id_wb_control)); compare(id_rs1); compare(id_rs2);
      next_cycle();
      ex_mem_read = 1'b0;
      expect_v("lu_release_stall", 32'h0); expect_v("lu_release_wb", 32'h2);
      #2; compare(32'(load_use_stall)); compare(32'(id_wb_control));

      // Load-use on rs2, none for ex_rd=0
      next_cycle();
      ex_mem_read = 1'b1; ex_rd = 5'd7;
      expect_v("lu_stall_rs2", 32'h1);
      #2; compare(32'(load_use_stall));
      next_cycle();
      if_instr = ADD_6_0_0; ex_rd = 5'd0;
      expect_v("lu_ex_rd_x0", 32'h0); expect_v("lu_ex_rd_x0_wb", 32'h2);
      #2; compare(32'(load_use_stall)); compare(32'(id_wb_control));

      // Branch beats load-use
      next_cycle();
      if_instr = ADD_6_5_7; ex_rd = 5'd5; branch = 1'b1;
      expect_v("br_stall", 32'h0); expect_v("br_ex_ctrl", 32'h0); expect_v("br_wb_ctrl", 32'h0);
      #2; compare(32'(load_use_stall)); compare(32'(id_ex_control)); compare(32'(id_wb_control));
      next_cycle();
      branch = 1'b0; ex_mem_read = 1'b0;

      // LUI does not use rs1 even when its rs1 field matches ex_rd
      if_instr = LUI_X1; ex_mem_read = 1'b1; ex_rd = 5'd27;
      expect_v("lui_no_stall", 32'h0); expect_v("lui_imm", 32'hABCDE000);
      expect_v("lui_ex_ctrl", 32'h14); expect_v("lui_wb_ctrl", 32'h2);
      #2;
      compare(32'(load_use_stall)); compare(id_immediate);
      compare(32'(id_ex_control)); compare(32'(id_wb_control));
      next_cycle();
      ex_mem_read = 1'b0;

      if_instr = BEQ_M4;
      expect_v("beq_imm", 32'hFFFFFFFC); expect_v("beq_ex_ctrl", 32'h21); expect_v("beq_wb_ctrl", 32'h0);
      #2; compare(id_immediate); compare(32'(id_ex_control)); compare(32'(id_wb_control));
      next_cycle();
      if_instr = SW_12;
      expect_v("sw_imm", 32'd12); expect_v("sw_ex_ctrl", 32'h04);
      expect_v("sw_mem_ctrl", 32'h1); expect_v("sw_funct3", 32'd2);
      #2; compare(id_immediate); compare(32'(id_ex_control)); compare(32'(id_mem_control)); compare(32'(id_funct_3));
      next_cycle();
      if_instr = LW_M1;
      expect_v("lw_imm", 32'hFFFFFFFF); expect_v("lw_mem_ctrl", 32'h2); expect_v("lw_wb_ctrl", 32'h3);
      #2; compare(id_immediate); compare(32'(id_mem_control)); compare(32'(id_wb_control));
      next_cycle();
      if_instr = JAL_2048;
      expect_v("jal_imm", 32'h00000800); expect_v("jal_ex_ctrl", 32'h40);
      #2; compare(id_immediate); compare(32'(id_ex_control));
      next_cycle();

      // Bubble when IF_ID is empty
      if_instr = ADD_6_5_0; if_valid = 1'b0;
      expect_v("invalid_wb_ctrl", 32'h0); expect_v("invalid_rs1_data", 32'hDEADBEEF);
      #2; compare(32'(id_wb_control)); compare(id_rs1);
      next_cycle();

      // FENCE is legal and a NOP; illegal under branch does not set the flag
      if_valid = 1'b1; if_instr = FENCE;
      expect_v("fence_ex_ctrl", 32'h0); expect_v("fence_imm", 32'h0);
      #2; compare(32'(id_ex_control)); compare(id_immediate);
      next_cycle();
      if_instr = BAD_OP; branch = 1'b1;
      next_cycle();
      branch = 1'b0; if_instr = ADD_6_5_0;
      expect_v("illegal_after_fence_branch", 32'h0);
      #2; compare(32'(illegal_instr));

      next_cycle();
      if_instr = BAD_OP;
      expect_v("illegal_bubble", 32'h0); expect_v("illegal_not_yet", 32'h0);
      #2; compare(32'(id_wb_control)); compare(32'(illegal_instr));
      next_cycle();
      if_instr = ADD_6_5_0;
      expect_v("illegal_set", 32'h1);
      #2; compare(32'(illegal_instr));
      next_cycle();
      expect_v("illegal_sticky", 32'h1);
      #2; compare(32'(illegal_instr));

      // Reset with a simultaneous writeback: reset wins
      next_cycle();
      reset = 1'b1; wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'hAAAA5555;
      next_cycle();
      reset = 1'b0; wb_reg_write = 1'b0; if_instr = ADD_6_5_7;
      expect_v("post_reset_illegal", 32'h0); expect_v("post_reset_x5", 32'h0);
      expect_v("post_reset_x7", 32'h0);
      #2; compare(32'(illegal_instr)); compare(id_rs1); compare(id_rs2);

      if (exp_q.size() != 0) begin
         errs++;
         $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
